// File: rtl/scrambler_seq.sv
// Frame sequencer for the serial LFSR scrambler: seed-load pulse, word fetch, MSB-first bit issue.
// Optional macro SCRAMBLER_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module scrambler_seq #(
  parameter int WORD_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       cfg_seed,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              scr_reset,
  output logic [31:0]       scr_seed,
  output logic              scr_enable,
  output logic              scr_data_in,
  output logic              out_bit_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic in_ready_q, in_ready_d;
  logic scr_reset_q, scr_reset_d;
  logic scr_enable_q, scr_enable_d;
  logic scr_data_in_q, scr_data_in_d;
  logic out_bit_valid_q, out_bit_valid_d;
  logic out_last_q, out_last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    out_last_d   = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d  = cfg_seed;
          len_d   = frame_len;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        words_left_d = len_q;
        if (len_q == {LEN_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          shift_d      = in_data;
          bit_cnt_d    = CNT_W'(WORD_W - 1);
          words_left_d = words_left_q - LEN_W'(1);
          state_d      = ST_SHIFT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        shift_d   = {shift_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == {CNT_W{1'b0}}) begin
          if (words_left_q == {LEN_W{1'b0}}) begin
            state_d    = ST_DONE;
            out_last_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every transition; the last-bit marker of a cut frame is dropped.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      aborted_d  = 1'b1;
      out_last_d = 1'b0;
    end else begin
      aborted_d = 1'b0;
    end

    scr_reset_d     = (state_d == ST_LOAD);
    in_ready_d      = (state_d == ST_FETCH);
    scr_enable_d    = (state_d == ST_SHIFT);
    scr_data_in_d   = (state_d == ST_SHIFT) ? shift_d[WORD_W-1] : 1'b0;
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_d == ST_DONE);
    out_bit_valid_d = scr_enable_q;
  end

  // Sequencer state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      seed_q          <= 32'd0;
      len_q           <= {LEN_W{1'b0}};
      words_left_q    <= {LEN_W{1'b0}};
      shift_q         <= {WORD_W{1'b0}};
      bit_cnt_q       <= {CNT_W{1'b0}};
      in_ready_q      <= 1'b0;
      scr_reset_q     <= 1'b0;
      scr_enable_q    <= 1'b0;
      scr_data_in_q   <= 1'b0;
      out_bit_valid_q <= 1'b0;
      out_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      seed_q          <= seed_d;
      len_q           <= len_d;
      words_left_q    <= words_left_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      in_ready_q      <= in_ready_d;
      scr_reset_q     <= scr_reset_d;
      scr_enable_q    <= scr_enable_d;
      scr_data_in_q   <= scr_data_in_d;
      out_bit_valid_q <= out_bit_valid_d;
      out_last_q      <= out_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign scr_reset     = scr_reset_q;
  assign scr_seed      = seed_q;
  assign scr_enable    = scr_enable_q;
  assign scr_data_in   = scr_data_in_q;
  assign out_bit_valid = out_bit_valid_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Completed frames counted on the done pulse; wraps naturally at 16 bits.
  always_comb begin
    if (done_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_scrambler_seq.sv
// Scoreboard bench for scrambler_seq: expected serial bits/last flags queued per frame,
// popped by an independent monitor whenever the DUT enables or marks a valid output bit.
module tb_scrambler_seq;
  localparam int WORD_W = 8;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset, start, abort, in_valid;
  logic [31:0]       cfg_seed;
  logic [LEN_W-1:0]  frame_len;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, scr_reset, scr_enable, scr_data_in;
  logic              out_bit_valid, out_last, busy, done, aborted;
  logic [31:0]       scr_seed;
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  scrambler_seq #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_seed(cfg_seed), .frame_len(frame_len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .scr_reset(scr_reset), .scr_seed(scr_seed), .scr_enable(scr_enable),
    .scr_data_in(scr_data_in), .out_bit_valid(out_bit_valid), .out_last(out_last),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit exp_bits[$];
  bit exp_last[$];
  int done_pend = 0;
  int abort_pend = 0;
  int frames_done = 0;
  bit mon_en = 1'b0;
  bit prev_en = 1'b0;
  bit mon_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_scr_reset"}, scr_reset, 0);
    check({tag, "_scr_seed"}, scr_seed, 0);
    check({tag, "_scr_enable"}, scr_enable, 0);
    check({tag, "_scr_data_in"}, scr_data_in, 0);
    check({tag, "_out_bit_valid"}, out_bit_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_aborted"}, aborted, 0);
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
    check({tag, "_frame_cnt"}, frame_cnt, 0);
`endif
  endtask

  // Monitor: pops the scoreboard on every enabled bit and every valid output bit.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_bit_valid_delay", out_bit_valid, prev_en);
      if (scr_enable) begin
        check("enable_has_expected_bit", exp_bits.size() > 0, 1);
        if (exp_bits.size() > 0) check("scr_data_in", scr_data_in, exp_bits.pop_front());
      end
      if (out_bit_valid) begin
        check("valid_has_expected_bit", exp_last.size() > 0, 1);
        if (exp_last.size() > 0) begin
          mon_l = exp_last.pop_front();
          check("out_last", out_last, mon_l);
          if (mon_l) check("done_with_last", done, 1);
        end
      end else begin
        check("out_last_without_valid", out_last, 0);
      end
      if (done) begin
        check("done_expected", done_pend > 0, 1);
        if (done_pend > 0) done_pend--;
      end
      if (aborted) begin
        check("aborted_expected", abort_pend > 0, 1);
        if (abort_pend > 0) abort_pend--;
      end
    end
    prev_en <= scr_enable;
  end

  // One frame: model queued up front, then handshake driven and timing checked per cycle.
  task automatic run_frame(input logic [31:0] seed, input int n, input int stall_mode,
                           input int abort_at, input int mid_start_at, input int reset_at,
                           input logic [WORD_W-1:0] w0, input bit fix_w0);
    logic [WORD_W-1:0] words[$];
    int k, idx, stalls, en_seen, low_cnt, first_en_k;
    bit fin, v, abort_phase, ms_sent;
    for (int i = 0; i < n; i++) words.push_back(WORD_W'($urandom));
    if (fix_w0 && n > 0) words[0] = w0;
    for (int i = 0; i < n * WORD_W; i++) begin
      if (abort_at == 0 || i < abort_at) begin
        exp_bits.push_back(words[i / WORD_W][WORD_W - 1 - (i % WORD_W)]);
        exp_last.push_back(abort_at == 0 && i == n * WORD_W - 1);
      end
    end
    if (abort_at > 0) abort_pend++;
    else done_pend++;

    @(negedge clk);
    start = 1'b1; cfg_seed = seed; frame_len = LEN_W'(n); in_valid = 1'b0;
    k = 0; idx = 0; stalls = 0; en_seen = 0; low_cnt = 0; first_en_k = 0;
    fin = 1'b0; abort_phase = 1'b0; ms_sent = 1'b0;
    while (!fin && k < 4000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (abort_phase) begin
        abort = 1'b0; in_valid = 1'b0;
        check("abort_aborted", aborted, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_enable", scr_enable, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_pending_valid", out_bit_valid, 1);
        fin = 1'b1;
      end else begin
        if (scr_enable) begin
          en_seen++;
          if (first_en_k == 0) first_en_k = k;
        end
        if (k == 1) begin
          check("load_scr_reset", scr_reset, 1);
          check("load_scr_seed", scr_seed, seed);
          check("load_busy", busy, 1);
        end
        if (k == 2) check("scr_reset_one_cycle", scr_reset, 0);
        if (in_ready) check("fetch_no_enable", scr_enable, 0);
        if (done) begin
          check("done_cycle", k, 2 + n * (WORD_W + 1) + stalls);
          check("bits_issued", en_seen, n * WORD_W);
          check("seed_held", scr_seed, seed);
          if (stall_mode == 0 && n > 0) check("first_enable_cycle", first_en_k, 3);
          frames_done++;
          in_valid = 1'b0;
          fin = 1'b1;
        end else if (reset_at > 0 && en_seen == reset_at) begin
          reset = 1'b1;
          #1 mon_en = 1'b0;
          @(negedge clk);
          check_all_zero("mid_reset");
          reset = 1'b0; in_valid = 1'b0;
          exp_bits.delete(); exp_last.delete();
          done_pend = 0; abort_pend = 0; frames_done = 0;
          #1 mon_en = 1'b1;
          fin = 1'b1;
        end else begin
          if (abort_at > 0 && en_seen == abort_at) begin
            abort = 1'b1;
            abort_phase = 1'b1;
          end
          if (mid_start_at > 0 && en_seen == mid_start_at && !ms_sent) begin
            start = 1'b1; cfg_seed = ~seed; frame_len = LEN_W'(n + 3);
            ms_sent = 1'b1;
          end
          v = 1'b0;
          if (idx < n) begin
            case (stall_mode)
              1: v = ($urandom_range(0, 2) != 0);
              2: begin
                if (idx == 1 && in_ready && low_cnt < 5) begin
                  v = 1'b0;
                  low_cnt++;
                end else begin
                  v = 1'b1;
                end
              end
              default: v = 1'b1;
            endcase
          end
          in_valid = v;
          in_data = (idx < n) ? words[idx] : {WORD_W{1'b0}};
          if (!v && in_ready) stalls++;
          if (v && in_ready) idx++;
        end
      end
    end
    check("frame_finished", fin, 1);
  endtask

  initial begin
    int n, ab;
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; cfg_seed = 32'd0; frame_len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");
    mon_en = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ignored", aborted, 0);
    check("idle_abort_busy", busy, 0);

    run_frame(32'h0000_0001, 1, 0, 0, 0, 0, 8'hA5, 1'b1);
    run_frame($urandom, 3, 2, 0, 0, 0, 8'h00, 1'b0);
    run_frame($urandom, 0, 0, 0, 0, 0, 8'h00, 1'b0);
    run_frame($urandom, 4, 0, WORD_W + 3, 0, 0, 8'h00, 1'b0);
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
    check("frame_cnt_after_abort", frame_cnt, 3);
`endif
    run_frame(32'h1234_5678, 2, 0, 0, 0, 0, 8'h00, 1'b0);
    run_frame($urandom, 3, 0, 0, 5, 0, 8'h00, 1'b0);
    run_frame($urandom, 2, 0, 0, 0, 4, 8'h00, 1'b0);

    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(0, 4);
      ab = 0;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n * WORD_W);
      run_frame($urandom, n, 1, ab, 0, 0, 8'h00, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("valids_drained", exp_last.size(), 0);
    check("done_drained", done_pend, 0);
    check("aborted_drained", abort_pend, 0);
    check("final_busy", busy, 0);
`ifdef SCRAMBLER_SEQ_FRAME_CNT_EN
    check("frame_cnt_final", frame_cnt, frames_done & 32'hFFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
